// File: rtl/adder3bit_inverse_serial.sv
// Bit-serial subtractor: recovers sayi1 = sum - sayi2 one bit per clock, LSB first.
// Define SUB_RANGE_CHECK_EN to drive range_err; otherwise range_err is tied low.
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one difference bit per cycle, WIDTH cycles
//   DONE  | result registered; start here begins the next operation
module adder3bit_inverse_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-2:0] sayi2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-2:0] sayi1,
  output logic             borrow,
  output logic             range_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d, br_n, load, last;

  always_comb begin
    d         = a_sh[0] ^ b_sh[0] ^ br;
    br_n      = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    load      = start && ((state == IDLE) || (state == DONE));
    last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // busy/done trail the state by one cycle so done never overlaps busy
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      cnt       <= '0;
      br        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sayi1     <= '0;
      borrow    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      busy <= (state == SHIFT);
      done <= (state == DONE);
      if (load) begin
        a_sh <= sum;
        b_sh <= {1'b0, sayi2};
        br   <= 1'b0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        br   <= br_n;
        res  <= {d, res[WIDTH-2:1]};
        cnt  <= cnt + 1'b1;
        if (last) begin
          // on the final bit, res already holds the low WIDTH-1 difference bits and d is the MSB
          sayi1  <= res;
          borrow <= br_n;
`ifdef SUB_RANGE_CHECK_EN
          range_err <= br_n | d;
`else
          range_err <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
